// File: rtl/taylor_core_arbiter_pkg.sv
// Shared constants, arbiter state type and range-check helper for the
// TaylorSeries cosine core arbiter.
package taylor_pkg;

    localparam int W         = 18;
    localparam int FRAC      = 16;
    localparam int ANGLE_MAX = 102943;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Unsigned compare; callers zero-extend the W-bit angle to 32 bits.
    function automatic logic angle_in_range(input logic [31:0] angle,
                                            input logic [31:0] limit);
        return angle <= limit;
    endfunction

endpackage

// File: rtl/taylor_core_arbiter_rr.sv
// Combinational round-robin grant: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant_onehot
);

    localparam int PW = $clog2(NREQ);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_onehot = '0;
        found        = 1'b0;
        idx          = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant_onehot[idx] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/taylor_core_arbiter.sv
// Shares one TaylorSeries cosine core between NREQ requesters: round-robin
// accept, range check, start pulse, completion-edge wait with timeout, response.
module taylor_core_arbiter #(
    parameter int W         = taylor_pkg::W,
    parameter int NREQ      = 4,
    parameter int ANGLE_MAX = taylor_pkg::ANGLE_MAX,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_angle,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_error,
    output logic              core_start,
    output logic [W-1:0]      core_angle,
    input  logic              core_ready,
    input  logic [W-1:0]      core_cos
);

    import taylor_pkg::*;

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state, state_next;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] owner;
    logic [NREQ-1:0] grant_onehot;
    logic [W-1:0]  sel_angle;
    logic [CW-1:0] wait_count;
    logic          err_flag;
    logic          core_ready_q;
    logic          accept;
    logic          in_range;
    logic          core_rise;
    logic          timeout_hit;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_onehot[i]) grant_idx = PW'(i);
        end
    end

    assign sel_angle   = req_angle[int'(grant_idx)*W +: W];
    assign in_range    = angle_in_range(32'(sel_angle), 32'(ANGLE_MAX));
    assign accept      = (state == IDLE) && !reset && (|grant_onehot);
    assign core_rise   = core_ready && !core_ready_q;
    assign timeout_hit = (wait_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Handshake strobes are decoded from state so they can never outlive it.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_error  = 1'b0;
        core_start = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset ? '0 : grant_onehot;
                if (accept) state_next = in_range ? ISSUE : RESP;
            end
            ISSUE: begin
                core_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_rise || timeout_hit) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = NREQ'(1) << owner;
                rsp_error  = err_flag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Completion edges seen outside WAIT only update the edge register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= '0;
            owner        <= '0;
            err_flag     <= 1'b0;
            wait_count   <= '0;
            core_ready_q <= 1'b0;
            rsp_data     <= '0;
            core_angle   <= '0;
        end else begin
            core_ready_q <= core_ready;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= grant_idx;
                        rr_ptr <= PW'((int'(grant_idx) + 1) % NREQ);
                        if (in_range) begin
                            core_angle <= sel_angle;
                            err_flag   <= 1'b0;
                        end else begin
                            err_flag <= 1'b1;
                            rsp_data <= '0;
                        end
                    end
                end
                ISSUE: wait_count <= '0;
                WAIT: begin
                    if (core_rise) begin
                        rsp_data <= core_cos;
                        err_flag <= 1'b0;
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                        rsp_data <= '0;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
